// File: rtl/football_pkg.sv
// rtl/football_pkg.sv - shared types and default constants for the football sprite path
package football_pkg;

  typedef logic [9:0] coord_t;
  typedef logic [3:0] pal_idx_t;

  localparam int SPRITE_W_DEF   = 32;
  localparam int SPRITE_H_DEF   = 32;
  localparam int N_FRAMES_DEF   = 4;
  localparam int FRAME_HOLD_DEF = 8;

  // Shared with the palette stage and background mux.
  localparam pal_idx_t TRANSPARENT_IDX = 4'd0;

endpackage

// File: rtl/football_anim_counter.sv
// rtl/football_anim_counter.sv - ball spin frame counter, advanced once per FRAME_HOLD moving vsyncs
module football_anim_counter
  import football_pkg::*;
#(
  parameter int N_FRAMES   = N_FRAMES_DEF,
  parameter int FRAME_HOLD = FRAME_HOLD_DEF,
  localparam int FR_W      = $clog2(N_FRAMES),
  localparam int HOLD_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            vsync_start,
  input  logic            ball_moving,
  output logic [FR_W-1:0] frame
);

  logic [HOLD_W-1:0] hold_cnt;

  // Count moving vsyncs; roll the frame when the hold count expires (power-of-two wrap).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_cnt <= '0;
      frame    <= '0;
    end else if (vsync_start && ball_moving) begin
      if (hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
        hold_cnt <= '0;
        frame    <= frame + 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/football_sprite_fetch.sv
// rtl/football_sprite_fetch.sv - per-pixel sprite ROM fetch and hit flag; spin animation under FOOTBALL_SPIN_EN
module football_sprite_fetch
  import football_pkg::*;
#(
  parameter int       SPRITE_W        = SPRITE_W_DEF,
  parameter int       SPRITE_H        = SPRITE_H_DEF,
  parameter int       N_FRAMES        = N_FRAMES_DEF,
  parameter int       FRAME_HOLD      = FRAME_HOLD_DEF,
  parameter pal_idx_t TRANSPARENT_IDX = football_pkg::TRANSPARENT_IDX,
`ifdef FOOTBALL_SPIN_EN
  parameter int       ADDR_W          = $clog2(N_FRAMES * SPRITE_W * SPRITE_H)
`else
  parameter int       ADDR_W          = $clog2(SPRITE_W * SPRITE_H)
`endif
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vsync_start,
  input  coord_t            ball_x,
  input  coord_t            ball_y,
  input  logic              ball_moving,
  input  coord_t            draw_x,
  input  coord_t            draw_y,
  input  logic              draw_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  pal_idx_t          rom_data,
  output pal_idx_t          pix_index,
  output logic              pix_hit,
  output logic              pix_valid
);

  localparam int DX_W = $clog2(SPRITE_W);
  localparam int DY_W = $clog2(SPRITE_H);

  coord_t            bx, by;
  logic [10:0]       x_end, y_end;
  coord_t            dx_full, dy_full;
  logic              hit0;
  logic [ADDR_W-1:0] addr0;
  logic              hit1, valid1, hit2, valid2;

`ifdef FOOTBALL_SPIN_EN
  localparam int FR_W = $clog2(N_FRAMES);
  logic [FR_W-1:0] frame;

  football_anim_counter #(
    .N_FRAMES   (N_FRAMES),
    .FRAME_HOLD (FRAME_HOLD)
  ) u_anim (
    .Clk         (Clk),
    .Reset       (Reset),
    .vsync_start (vsync_start),
    .ball_moving (ball_moving),
    .frame       (frame)
  );

  assign addr0 = {frame, dy_full[DY_W-1:0], dx_full[DX_W-1:0]};

  logic unused_bits;
  assign unused_bits = ^{dx_full[9:DX_W], dy_full[9:DY_W]};
`else
  // Single-frame ROM: ball_moving is accepted but has no effect.
  assign addr0 = {dy_full[DY_W-1:0], dx_full[DX_W-1:0]};

  logic unused_bits;
  assign unused_bits = ^{ball_moving, dx_full[9:DX_W], dy_full[9:DY_W]};
`endif

  // Latch the ball position only at vblank so a visible frame never tears.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bx <= 10'h3FF;
      by <= 10'h3FF;
    end else if (vsync_start) begin
      bx <= ball_x;
      by <= ball_y;
    end
  end

  // 11-bit bounds so a sprite past the right/bottom edge clips instead of wrapping.
  assign x_end   = {1'b0, bx} + 11'(SPRITE_W);
  assign y_end   = {1'b0, by} + 11'(SPRITE_H);
  assign dx_full = draw_x - bx;
  assign dy_full = draw_y - by;
  assign hit0    = draw_valid
                && (draw_x >= bx) && ({1'b0, draw_x} < x_end)
                && (draw_y >= by) && ({1'b0, draw_y} < y_end);

  // Stage 1/2 pipeline; rom_addr holds on misses since the extra read is harmless.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      hit1     <= 1'b0;
      valid1   <= 1'b0;
      hit2     <= 1'b0;
      valid2   <= 1'b0;
    end else begin
      if (hit0) rom_addr <= addr0;
      hit1   <= hit0;
      valid1 <= draw_valid;
      hit2   <= hit1;
      valid2 <= valid1;
    end
  end

  // Output stage: combine BRAM data with the aligned hit flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_index <= TRANSPARENT_IDX;
      pix_hit   <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      pix_index <= hit2 ? rom_data : TRANSPARENT_IDX;
      pix_hit   <= hit2 && (rom_data != TRANSPARENT_IDX);
      pix_valid <= valid2;
    end
  end

endmodule

// File: tb/tb_football_sprite_fetch.sv
// tb/tb_football_sprite_fetch.sv - directed self-checking bench for football_sprite_fetch
module tb_football_sprite_fetch;
  import football_pkg::*;

`ifdef FOOTBALL_SPIN_EN
  localparam int ADDR_W = 12;
`else
  localparam int ADDR_W = 10;
`endif

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              vsync_start = 1'b0;
  coord_t            ball_x = '0;
  coord_t            ball_y = '0;
  logic              ball_moving = 1'b0;
  coord_t            draw_x = '0;
  coord_t            draw_y = '0;
  logic              draw_valid = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  pal_idx_t          rom_data = '0;
  pal_idx_t          pix_index;
  logic              pix_hit;
  logic              pix_valid;

  int vectors = 0;
  int miscompares = 0;

  football_sprite_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .vsync_start (vsync_start),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_moving (ball_moving),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .draw_valid  (draw_valid),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_index   (pix_index),
    .pix_hit     (pix_hit),
    .pix_valid   (pix_valid)
  );

  always #5 Clk = ~Clk;

  // Synchronous BRAM stand-in: contents are (addr + 3) mod 16.
  always @(posedge Clk) rom_data <= rom_addr[3:0] + 4'd3;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic vsync(input int x, input int y);
    ball_x = 10'(x);
    ball_y = 10'(y);
    vsync_start = 1'b1;
    step();
    vsync_start = 1'b0;
  endtask

  // One pixel through the pipe; exp_addr < 0 skips the address check.
  task automatic pixel(input string tag, input int x, input int y,
                       input int exp_addr, input int exp_idx, input int exp_hit);
    draw_x = 10'(x);
    draw_y = 10'(y);
    draw_valid = 1'b1;
    step();
    draw_valid = 1'b0;
    if (exp_addr >= 0) check({tag, ".addr"}, int'(rom_addr), exp_addr);
    step();
    step();
    check({tag, ".idx"}, int'(pix_index), exp_idx);
    check({tag, ".hit"}, int'(pix_hit), exp_hit);
    check({tag, ".valid"}, int'(pix_valid), 1);
  endtask

  initial begin
    step();
    step();
    check("rst.addr", int'(rom_addr), 0);
    check("rst.idx", int'(pix_index), 0);
    check("rst.hit", int'(pix_hit), 0);
    check("rst.valid", int'(pix_valid), 0);
    Reset = 1'b0;

    pixel("prevsync", 1022, 479, 0, 0, 0);

    vsync(100, 50);
    pixel("topleft", 100, 50, 0, 3, 1);
    pixel("botright", 131, 81, 1023, 2, 1);
    pixel("pastright", 132, 50, 1023, 0, 0);
    pixel("transp", 113, 50, 13, 0, 0);

    ball_x = 10'd200;
    pixel("notear", 100, 50, 0, 3, 1);
    vsync(200, 50);
    pixel("oldpos", 100, 50, -1, 0, 0);
    pixel("newpos", 200, 50, 0, 3, 1);

    vsync(620, 100);
    pixel("clip639", 639, 110, 339, 6, 1);
    pixel("clip640", 640, 100, 20, 7, 1);
    pixel("nowrap", 0, 110, -1, 0, 0);

    // vsync coincident with a pixel: the pixel still sees the old position
    ball_x = 10'd300;
    ball_y = 10'd100;
    vsync_start = 1'b1;
    draw_x = 10'd620;
    draw_y = 10'd100;
    draw_valid = 1'b1;
    step();
    vsync_start = 1'b0;
    draw_valid = 1'b0;
    check("simul.addr", int'(rom_addr), 0);
    step();
    step();
    check("simul.hit", int'(pix_hit), 1);
    pixel("simul.new", 301, 100, 1, 4, 1);

`ifdef FOOTBALL_SPIN_EN
    ball_moving = 1'b1;
    for (int i = 0; i < 8; i++) vsync(100, 50);
    pixel("frame1", 100, 50, 1024, 3, 1);
    pixel("frame1.br", 131, 81, 2047, 2, 1);
    for (int i = 0; i < 24; i++) vsync(100, 50);
    pixel("frame0", 100, 50, 0, 3, 1);
    ball_moving = 1'b0;
    for (int i = 0; i < 8; i++) vsync(100, 50);
    pixel("frozen", 101, 50, 1, 4, 1);
`endif

    // reset with a pixel in flight: it must be dropped
    draw_x = 10'd301;
    draw_y = 10'd100;
    draw_valid = 1'b1;
    step();
    draw_valid = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst.addr", int'(rom_addr), 0);
    check("midrst.valid", int'(pix_valid), 0);
    step();
    step();
    check("midrst.drop", int'(pix_valid), 0);
    pixel("midrst.nohit", 301, 100, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/football_sprite_fetch.md
# football_sprite_fetch

Per-pixel sprite fetch stage that sits directly upstream of the football palette lookup. It converts the VGA controller's draw coordinates and the latched ball position into a sprite ROM address, and reads a 4-bit colour index from an external synchronous BRAM. It emits that index and a hit flag, pipeline-aligned, to the palette stage and the background mux. It also owns the ball's spin-animation frame counter.

## Interface
- `SPRITE_W`, default 32: sprite width in pixels; power of two.
- `SPRITE_H`, default 32: sprite height in pixels; power of two.
- `N_FRAMES`, default 4: number of animation frames stored back-to-back in the ROM; power of two.
- `FRAME_HOLD`, default 8: number of `vsync_start` pulses each animation frame is shown.
- `TRANSPARENT_IDX`, default 4'd0: ROM index treated as transparent.
- `ADDR_W`, derived: $clog2(N_FRAMES*SPRITE_W*SPRITE_H); 12 with the defaults.
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high.
- `vsync_start` in 1: one-cycle pulse on the first cycle of vertical blanking.
- `ball_x`, `ball_y` in 10 each: sprite top-left position, unsigned; sampled only on `vsync_start`.
- `ball_moving` in 1: spin enable; sampled on `vsync_start`.
- `draw_x`, `draw_y` in 10 each: current pixel coordinate.
- `draw_valid` in 1: active-video qualifier for `draw_x`/`draw_y`.
- `rom_addr` out ADDR_W: sprite BRAM address (registered).
- `rom_data` in 4: BRAM read data; valid one cycle after `rom_addr`.
- `pix_index` out 4: colour index for the palette stage.
- `pix_hit` out 1: this pixel is an opaque sprite pixel.
- `pix_valid` out 1: `draw_valid` delayed to align with `pix_index`.

## Operation
- **Position shadow regs** `bx`, `by`:
  - Load `ball_x`/`ball_y` on `vsync_start`; otherwise hold. Mid-frame input changes never tear the sprite.
  - Reset value is 10'h3FF, so there is no hit until the first `vsync_start`.
- **Hit test** (combinational, stage 0):
  - Condition: `draw_valid && draw_x >= bx && {1'b0,draw_x} < bx+SPRITE_W && draw_y >= by && {1'b0,draw_y} < by+SPRITE_H`.
  - Sums are computed at 11 bits, with no wrap. A sprite off the right or bottom edge is clipped. Left/top clipping is not supported.
- **Address:** `frame*SPRITE_W*SPRITE_H + dy*SPRITE_W + dx`, where `dx = draw_x-bx` and `dy = draw_y-by`, each truncated to log2 of the sprite dimension. Because all dimensions are powers of two, this is pure concatenation.
- **Pipeline:**
  - Stage 1 registers `rom_addr`, `hit1`, `valid1`.
  - The BRAM returns `rom_data` during stage 2.
  - The output stage registers `pix_index = hit2 ? rom_data : TRANSPARENT_IDX`, `pix_hit = hit2 && rom_data != TRANSPARENT_IDX`, and `pix_valid = valid2`.
  - `rom_addr` holds its last value when there is no hit. The only constraint is that the BRAM read is harmless.
- **Animation counter:**
  - State is `hold_cnt` (0..FRAME_HOLD-1) and `frame` (0..N_FRAMES-1).
  - On `vsync_start` with `ball_moving=1`: if `hold_cnt == FRAME_HOLD-1`, then `hold_cnt` goes to 0 and `frame` goes to `(frame+1) mod N_FRAMES`; otherwise `hold_cnt` increments.
  - On `vsync_start` with `ball_moving=0`: both hold.
  - `frame` changes only at `vsync_start`, so it is constant across a visible frame.
- **Simultaneous events:** if `vsync_start` and `draw_valid` are both high, the current pixel uses the old `bx`/`by`/`frame`, and the new values apply from the next cycle.

## Timing
- Latency is 3 cycles: `draw_*` at cycle t gives `rom_addr` valid at t+1, `rom_data` at t+2, and `pix_*` at t+3.
- Throughput is one pixel per clock, with no stalls.
- Reset values:
  - `rom_addr` = 0, `pix_index` = TRANSPARENT_IDX, `pix_hit` = 0, `pix_valid` = 0.
  - `bx` = `by` = 10'h3FF, `frame` = 0, `hold_cnt` = 0.
  - All pipeline flags are 0.
- Reset mid-frame: outputs return to their reset values on the cycle after `Reset` is sampled high. Pixels already in flight are dropped.

## Configuration
- `FOOTBALL_SPIN_EN` defined: the animation counter is present and the address includes the `frame` field.
- `FOOTBALL_SPIN_EN` undefined:
  - `frame` is tied to 0 and `ADDR_W` = $clog2(SPRITE_W*SPRITE_H).
  - `ball_moving` is ignored; the port stays present.
  - The ROM holds a single frame.

## Structure
- `football_pkg` holds:
  - `coord_t` (logic [9:0]) and `pal_idx_t` (logic [3:0]).
  - Default `SPRITE_W`, `SPRITE_H`, `N_FRAMES`, `FRAME_HOLD` constants.
  - The `TRANSPARENT_IDX` constant, which is shared with the palette and background mux.
- Sub-module `football_anim_counter` (`Clk`, `Reset`, `vsync_start`, `ball_moving` → `frame`). It is instantiated only under `FOOTBALL_SPIN_EN`.

## Test plan
- **Reset and pre-vsync:** hold `Reset` 2 cycles, then drive `draw_valid=1` at (1022,479) before any `vsync_start` → all outputs stay at reset values and `pix_hit=0` throughout.
- **Basic hit:** latch `ball_x=100`, `ball_y=50`, then draw (100,50) → `rom_addr=0` at t+1. With the BRAM returning 4'h3 → `pix_index=3`, `pix_hit=1` at t+3. Draw (131,81) → `rom_addr=1023`. Draw (132,50) → `pix_hit=0`, `pix_index=0`.
- **Transparency:** inside the sprite with `rom_data=4'h0` → `pix_hit=0`, `pix_valid=1`.
- **No tearing:** change `ball_x` to 200 mid-frame without `vsync_start` → a hit is still at x=100. After `vsync_start` → a hit at x=200.
- **Animation (spin build):** `ball_moving=1` for 8 vsyncs → frame 1, and (100,50) maps to `rom_addr=1024`. After 32 vsyncs → back to frame 0. `ball_moving=0` → frame frozen.
- **Right-edge clip:** `ball_x=620`, draw (639,y inside) → hit with `rom_addr` low bits `dx=19`. No wrap to x=0.
